// File: rtl/stage_memory.sv
// stage_memory: pipeline stage following execute.
// Non-memory results are forwarded to writeback with one cycle of latency.
// Aligned loads/stores run a req/ack transaction on the data-memory bus and
// stall upstream until the ack arrives or the timeout expires. Misaligned
// accesses raise mem_fault without touching the bus.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_addr, in_val               destination/value from execute (in_addr 0 = no wb)
//   is_mem, mem_addr, mem_val,
//   mem_write                     load/store request from execute
//   stall                         combinational hold for upstream stages
//   dmem_req/addr/wdata/we        registered data-memory bus request
//   dmem_ack, dmem_rdata          bus completion and load data
//   wb_addr, wb_val               registered writeback pair
//   mem_fault                     one-cycle pulse on misalignment or timeout
module stage_memory #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_addr,
  input  logic [31:0] in_val,
  input  logic        is_mem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  input  logic        mem_write,
  output logic        stall,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_val,
  output logic        mem_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dest;
  logic             aligned;
  logic             timeout_hit;

  assign aligned     = (mem_addr[1:0] == 2'b00);
  assign timeout_hit = (state == BUSY) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    stall = 1'b0;
    if (state == IDLE)
      stall = is_mem && aligned;
    else
      stall = !dmem_ack && !timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dest       <= '0;
      dmem_req   <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_we    <= 1'b0;
      wb_addr    <= '0;
      wb_val     <= '0;
      mem_fault  <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_addr <= in_addr;
            wb_val  <= in_val;
          end else if (!aligned) begin
            mem_fault <= 1'b1;
            wb_addr   <= '0;
          end else begin
            dmem_addr  <= mem_addr;
            dmem_wdata <= mem_val;
            dmem_we    <= mem_write;
            dest       <= in_addr;
            dmem_req   <= 1'b1;
            cnt        <= '0;
            wb_addr    <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            if (dmem_we) begin
              wb_addr <= '0;
            end else begin
              wb_addr <= dest;
              wb_val  <= dmem_rdata;
            end
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            mem_fault <= 1'b1;
            wb_addr   <= '0;
            state     <= IDLE;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            wb_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
